// File: rtl/dcache_wb_if.sv
// rtl/dcache_wb_if.sv - CPU and external-memory bus bundle for dcache_wb
//
// Purpose: groups the CPU request/response signals and the line-wide
// external memory handshake into one interface.
// Modports:
//   slave  - cache view: CPU request and memory response in; load data,
//            stall and memory request out.
//   master - environment view (CPU plus memory): the reverse.
// Signals:
//   p_addr_i/p_read_i/p_write_i/p_data_i  CPU request (held while stalled)
//   p_data_o/p_stall_o                    load data, pipeline freeze
//   mem_addr_o/mem_data_o                 line-aligned address, write-back line
//   mem_enable_o/mem_write_o              request, 1 = write / 0 = read
//   mem_data_i/mem_ack_i                  refill line, one-cycle completion
interface dcache_wb_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       p_addr_i;
  logic              p_read_i;
  logic              p_write_i;
  logic [31:0]       p_data_i;
  logic [31:0]       p_data_o;
  logic              p_stall_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  p_addr_i, p_read_i, p_write_i, p_data_i, mem_data_i, mem_ack_i,
    output p_data_o, p_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

  modport master (
    output p_addr_i, p_read_i, p_write_i, p_data_i, mem_data_i, mem_ack_i,
    input  p_data_o, p_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back, write-allocate data cache
//
// Purpose: single-port data cache between a stalling CPU pipeline and a
// line-wide external memory. Hits complete combinationally in IDLE; misses
// freeze the pipeline, optionally write back a dirty victim, then refill.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     CPU request/response and external memory handshake
//   hit_cnt_o       saturating count of hits (post-refill retry excluded)
//   miss_cnt_o      saturating count of misses
module dcache_wb #(
  parameter int SETS   = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  dcache_wb_if.slave       bus,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF - IDX_W;
  localparam int WORDS  = LINE_W / 32;
  localparam int WSEL_W = OFF - 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0]        state_q;
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;
  logic              retry_q;
  // High for the first cycle after reset: requests are not accepted so the
  // pipeline sees no stall while the cache comes out of reset.
  logic              post_rst_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] wsel;
  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] wr_line;
  logic [31:0]       rd_word;
  logic              hit;
  logic              req;
  logic              is_wr;
  logic              idle_req;
  logic              mem_ack;

  assign idx     = bus.p_addr_i[OFF +: IDX_W];
  assign req_tag = bus.p_addr_i[31 -: TAG_W];
  assign wsel    = bus.p_addr_i[OFF-1:2];
  assign line    = data_mem[idx];
  assign hit     = valid_q[idx] && (tag_mem[idx] == req_tag);
  assign req     = bus.p_read_i | bus.p_write_i;
  // A simultaneous read and write is handled as a write.
  assign is_wr   = bus.p_write_i;
  assign mem_ack = bus.mem_ack_i;

  assign idle_req = (state_q == S_IDLE) && !post_rst_q && !rst && req;

  // Word extract for loads and word merge for stores.
  always_comb begin
    rd_word = '0;
    wr_line = line;
    for (int w = 0; w < WORDS; w++) begin
      if (wsel == WSEL_W'(w)) begin
        rd_word               = line[w*32 +: 32];
        wr_line[w*32 +: 32]   = bus.p_data_i;
      end
    end
  end

  // CPU side
  assign bus.p_data_o  = (idle_req && hit) ? rd_word : 32'd0;
  assign bus.p_stall_o = !rst && ((idle_req && !hit) || (state_q != S_IDLE));

  // Memory side; address and data track the held CPU address, which stays
  // stable for the whole miss, so they are stable until the ack.
  assign bus.mem_enable_o = !rst && (state_q != S_IDLE);
  assign bus.mem_write_o  = !rst && (state_q == S_WRITEBACK);
  assign bus.mem_addr_o   = {(state_q == S_WRITEBACK) ? tag_mem[idx] : req_tag,
                             idx, {OFF{1'b0}}};
  assign bus.mem_data_o   = line;

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // Control state, line status bits and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      post_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          retry_q <= 1'b0;
          if (idle_req) begin
            if (hit) begin
              if (is_wr) begin
                dirty_q[idx] <= 1'b1;
              end
              // The refill retry is the same access that was already counted
              // as a miss, so it does not count as a hit.
              if (!retry_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
              end
            end else begin
              if (miss_cnt_q != {CNT_W{1'b1}}) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
              end
              state_q <= (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) begin
            state_q <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (mem_ack) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            retry_q      <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; reset only blocks updates so an
  // aborted refill cannot land in the array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state_q == S_ALLOCATE) && mem_ack) begin
        tag_mem[idx]  <= req_tag;
        data_mem[idx] <= bus.mem_data_i;
      end else if (idle_req && hit && is_wr) begin
        data_mem[idx] <= wr_line;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - directed self-checking bench for dcache_wb
module tb_dcache_wb;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wb_if #(.LINE_W(LINE_W)) bus ();
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  dcache_wb #(.SETS(32), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [LINE_W-1:0] mem_lines [logic [31:0]];
  bit                resp_on;
  int                wait_cnt;
  int                wb_count;
  int                rd_count;
  logic [31:0]       last_wb_addr;
  logic [31:0]       last_rd_addr;
  logic [LINE_W-1:0] last_wb_data;

  function automatic logic [LINE_W-1:0] pat_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = {a[15:0], 8'hA5, 8'(w)};
    return l;
  endfunction

  // External memory: ack one cycle after the request is seen.
  initial begin
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_on) begin
        if (bus.mem_ack_i) begin
          bus.mem_ack_i = 1'b0;
          wait_cnt = 0;
        end
        if (bus.mem_enable_o) begin
          if (wait_cnt < 1) begin
            wait_cnt++;
          end else begin
            wait_cnt = 0;
            if (bus.mem_write_o) begin
              mem_lines[bus.mem_addr_o] = bus.mem_data_o;
              last_wb_addr = bus.mem_addr_o;
              last_wb_data = bus.mem_data_o;
              wb_count++;
            end else begin
              bus.mem_data_i = mem_lines.exists(bus.mem_addr_o) ?
                               mem_lines[bus.mem_addr_o] : pat_line(bus.mem_addr_o);
              last_rd_addr = bus.mem_addr_o;
              rd_count++;
            end
            bus.mem_ack_i = 1'b1;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.p_read_i = 1'b0; bus.p_write_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output int stalls, output bit to);
    bit done;
    @(posedge clk);
    #1;
    bus.p_addr_i = a; bus.p_data_i = d; bus.p_read_i = rd; bus.p_write_i = wr;
    stalls = 0; done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!bus.p_stall_o) done = 1'b1;
      else stalls++;
    end
    to = !done;
    q = bus.p_data_o;
    @(posedge clk);
    #1;
    bus.p_read_i = 1'b0; bus.p_write_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.p_addr_i = 32'h40; bus.p_data_i = '0; bus.p_read_i = 1'b1; bus.p_write_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++; if (bus.p_stall_o !== 1'b0) begin err_cnt++; $display("FAIL rst_stall: got %b expected 0", bus.p_stall_o); end
    vec_cnt++; if (bus.mem_enable_o !== 1'b0) begin err_cnt++; $display("FAIL rst_enable: got %b expected 0", bus.mem_enable_o); end
    vec_cnt++; if (bus.mem_write_o !== 1'b0) begin err_cnt++; $display("FAIL rst_write: got %b expected 0", bus.mem_write_o); end
    vec_cnt++; if (bus.p_data_o !== 32'h0) begin err_cnt++; $display("FAIL rst_pdata: got %h expected 0", bus.p_data_o); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus.p_stall_o !== 1'b0) begin err_cnt++; $display("FAIL post_rst_stall: got %b expected 0", bus.p_stall_o); end
    vec_cnt++; if (bus.mem_enable_o !== 1'b0) begin err_cnt++; $display("FAIL post_rst_enable: got %b expected 0", bus.mem_enable_o); end
    vec_cnt++; if (bus.p_data_o !== 32'h0) begin err_cnt++; $display("FAIL post_rst_pdata: got %h expected 0", bus.p_data_o); end
    vec_cnt++; if (hit_cnt !== 4'd0) begin err_cnt++; $display("FAIL rst_hit_cnt: got %0d expected 0", hit_cnt); end
    vec_cnt++; if (miss_cnt !== 4'd0) begin err_cnt++; $display("FAIL rst_miss_cnt: got %0d expected 0", miss_cnt); end
    bus.p_read_i = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (miss_cnt !== 4'd0) begin err_cnt++; $display("FAIL rst_no_miss: got %0d expected 0", miss_cnt); end
  endtask

  task automatic test_cold_read();
    logic [31:0] q; int st; bit to;
    rd_count = 0;
    access(1'b1, 1'b0, 32'h40, 32'h0, q, st, to);
    vec_cnt++; if (to) begin err_cnt++; $display("FAIL cold_timeout: got timeout expected completion"); end
    vec_cnt++; if (st != 3) begin err_cnt++; $display("FAIL cold_stalls: got %0d expected 3", st); end
    vec_cnt++; if (q !== 32'h1234_5678) begin err_cnt++; $display("FAIL cold_data: got %h expected 12345678", q); end
    vec_cnt++; if (last_rd_addr !== 32'h40 || rd_count != 1) begin err_cnt++; $display("FAIL cold_alloc: got addr %h count %0d expected 00000040 1", last_rd_addr, rd_count); end
    vec_cnt++; if (miss_cnt !== 4'd1) begin err_cnt++; $display("FAIL cold_miss_cnt: got %0d expected 1", miss_cnt); end
    vec_cnt++; if (hit_cnt !== 4'd0) begin err_cnt++; $display("FAIL cold_hit_cnt: got %0d expected 0", hit_cnt); end
  endtask

  task automatic test_write_hit();
    logic [31:0] q; int st; bit to;
    access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, q, st, to);
    vec_cnt++; if (to || st != 0) begin err_cnt++; $display("FAIL wr_hit_stalls: got %0d expected 0", st); end
    vec_cnt++; if (hit_cnt !== 4'd1) begin err_cnt++; $display("FAIL wr_hit_cnt: got %0d expected 1", hit_cnt); end
    access(1'b1, 1'b0, 32'h44, 32'h0, q, st, to);
    vec_cnt++; if (to || st != 0) begin err_cnt++; $display("FAIL rd_hit_stalls: got %0d expected 0", st); end
    vec_cnt++; if (q !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL rd_hit_data: got %h expected deadbeef", q); end
    vec_cnt++; if (hit_cnt !== 4'd2) begin err_cnt++; $display("FAIL rd_hit_cnt: got %0d expected 2", hit_cnt); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] q; int st; bit to;
    logic [LINE_W-1:0] exp_line;
    exp_line = pat_line(32'h40);
    exp_line[31:0]  = 32'h1234_5678;
    exp_line[63:32] = 32'hDEAD_BEEF;
    wb_count = 0; rd_count = 0;
    access(1'b1, 1'b0, 32'h440, 32'h0, q, st, to);
    vec_cnt++; if (to || st != 5) begin err_cnt++; $display("FAIL evict_stalls: got %0d expected 5", st); end
    vec_cnt++; if (wb_count != 1 || last_wb_addr !== 32'h40) begin err_cnt++; $display("FAIL evict_wb_addr: got %h count %0d expected 00000040 1", last_wb_addr, wb_count); end
    vec_cnt++; if (last_wb_data !== exp_line) begin err_cnt++; $display("FAIL evict_wb_data: got word1 %h word0 %h expected deadbeef 12345678", last_wb_data[63:32], last_wb_data[31:0]); end
    vec_cnt++; if (rd_count != 1 || last_rd_addr !== 32'h440) begin err_cnt++; $display("FAIL evict_alloc_addr: got %h expected 00000440", last_rd_addr); end
    vec_cnt++; if (q !== 32'h0440_A500) begin err_cnt++; $display("FAIL evict_data: got %h expected 0440a500", q); end
    vec_cnt++; if (miss_cnt !== 4'd2) begin err_cnt++; $display("FAIL evict_miss_cnt: got %0d expected 2", miss_cnt); end
    vec_cnt++; if (hit_cnt !== 4'd2) begin err_cnt++; $display("FAIL evict_hit_cnt: got %0d expected 2", hit_cnt); end
  endtask

  task automatic test_rw_both();
    logic [31:0] q; int st; bit to;
    wb_count = 0;
    access(1'b1, 1'b1, 32'h88, 32'hCAFE_F00D, q, st, to);
    vec_cnt++; if (to || st != 3) begin err_cnt++; $display("FAIL rw_stalls: got %0d expected 3", st); end
    vec_cnt++; if (miss_cnt !== 4'd3) begin err_cnt++; $display("FAIL rw_miss_cnt: got %0d expected 3", miss_cnt); end
    vec_cnt++; if (wb_count != 0) begin err_cnt++; $display("FAIL rw_no_wb: got %0d expected 0", wb_count); end
    access(1'b1, 1'b0, 32'h488, 32'h0, q, st, to);
    vec_cnt++; if (to || st != 5) begin err_cnt++; $display("FAIL rw_dirty_stalls: got %0d expected 5", st); end
    vec_cnt++; if (wb_count != 1 || last_wb_addr !== 32'h80) begin err_cnt++; $display("FAIL rw_wb_addr: got %h count %0d expected 00000080 1", last_wb_addr, wb_count); end
    vec_cnt++; if (last_wb_data[95:64] !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL rw_wb_word: got %h expected cafef00d", last_wb_data[95:64]); end
    vec_cnt++; if (q !== 32'h0480_A502 || last_rd_addr !== 32'h480) begin err_cnt++; $display("FAIL rw_refill: got %h at %h expected 0480a502 at 00000480", q, last_rd_addr); end
    vec_cnt++; if (miss_cnt !== 4'd4 || hit_cnt !== 4'd2) begin err_cnt++; $display("FAIL rw_counters: got miss %0d hit %0d expected 4 2", miss_cnt, hit_cnt); end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    resp_on = 1'b0;
    @(posedge clk); #1;
    bus.p_addr_i = 32'h100; bus.p_read_i = 1'b1;
    @(negedge clk);
    vec_cnt++; if (bus.p_stall_o !== 1'b1) begin err_cnt++; $display("FAIL abort_miss_stall: got %b expected 1", bus.p_stall_o); end
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++; if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h100) begin
      err_cnt++; $display("FAIL abort_alloc: got en %b wr %b addr %h expected 1 0 00000100", bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o);
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.p_read_i = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus.mem_enable_o !== 1'b0 || bus.p_stall_o !== 1'b0 || bus.p_data_o !== 32'h0) begin
      err_cnt++; $display("FAIL abort_in_rst: got en %b stall %b data %h expected 0 0 0", bus.mem_enable_o, bus.p_stall_o, bus.p_data_o);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.p_stall_o !== 1'b0) begin
      err_cnt++; $display("FAIL abort_after_rst: got en %b wr %b stall %b expected 0 0 0", bus.mem_enable_o, bus.mem_write_o, bus.p_stall_o);
    end
    bus.mem_data_i = '1; bus.mem_ack_i = 1'b1;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    vec_cnt++; if (bus.mem_enable_o !== 1'b0) begin err_cnt++; $display("FAIL late_ack_enable: got %b expected 0", bus.mem_enable_o); end
    vec_cnt++; if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin err_cnt++; $display("FAIL late_ack_counters: got hit %0d miss %0d expected 0 0", hit_cnt, miss_cnt); end
    @(posedge clk); #1;
    bus.p_addr_i = 32'h100; bus.p_read_i = 1'b1;
    @(negedge clk);
    vec_cnt++; if (bus.p_stall_o !== 1'b1) begin err_cnt++; $display("FAIL late_ack_line_invalid: got stall %b expected 1", bus.p_stall_o); end
    bus.p_read_i = 1'b0;
    @(posedge clk); #1;
    resp_on = 1'b1;
  endtask

  task automatic test_saturate();
    logic [31:0] q; int st; bit to;
    apply_reset();
    access(1'b1, 1'b0, 32'h40, 32'h0, q, st, to);
    vec_cnt++; if (to || q !== 32'h1234_5678) begin err_cnt++; $display("FAIL sat_refill: got %h expected 12345678", q); end
    bus.p_addr_i = 32'h40; bus.p_read_i = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    vec_cnt++; if (hit_cnt !== 4'd14) begin err_cnt++; $display("FAIL sat_count14: got %0d expected 14", hit_cnt); end
    repeat (6) @(posedge clk);
    #1;
    vec_cnt++; if (hit_cnt !== 4'd15) begin err_cnt++; $display("FAIL sat_hold15: got %0d expected 15", hit_cnt); end
    bus.p_read_i = 1'b0;
    vec_cnt++; if (miss_cnt !== 4'd1) begin err_cnt++; $display("FAIL sat_miss_cnt: got %0d expected 1", miss_cnt); end
  endtask

  initial begin
    logic [LINE_W-1:0] l;
    resp_on = 1'b1;
    wb_count = 0; rd_count = 0;
    last_wb_addr = '0; last_rd_addr = '0; last_wb_data = '0;
    l = pat_line(32'h40);
    l[31:0] = 32'h1234_5678;
    mem_lines[32'h40] = l;
    bus.p_addr_i = '0; bus.p_data_i = '0; bus.p_read_i = 1'b0; bus.p_write_i = 1'b0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_rw_both();
    test_reset_abort();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
